// File: rtl/cc_levels_pkg.sv
// Shared level-sequencing definitions: FSM state encodings and default level limits.
// The level comparator imports the same MAX_LEVEL default so both blocks agree on the final level.
package cc_levels_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_WIN   = 2'd3
  } level_state_e;

  localparam int DEFAULT_MAX_LEVEL   = 5;
  localparam int DEFAULT_LEVEL_WIDTH = 5;

endpackage

// File: rtl/cc_edge_detect.sv
// Rising-edge detector with a configurable reset value for the history flop.
// Resetting the history to 1 suppresses an edge for inputs already active when reset releases.
module cc_edge_detect #(
  parameter logic RESET_PREV = 1'b1
) (
  input  logic clk,
  input  logic srst,
  input  logic sig_in,
  output logic edge_out
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = sig_in;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      prev_q <= RESET_PREV;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign edge_out = sig_in & ~prev_q;

endmodule

// File: rtl/cc_level_sequencer.sv
// Game level sequencer: start -> level 1, each level-done edge advances through a fixed pause
// and playfield reload, and completing MAX_LEVEL declares the win until the next start press.
module cc_level_sequencer
  import cc_levels_pkg::*;
#(
  parameter int COUNTER_LEVELS_DATAWIDTH = DEFAULT_LEVEL_WIDTH,
  parameter int MAX_LEVEL                = DEFAULT_MAX_LEVEL,
  parameter int PAUSE_CYCLES             = 25000000
) (
  input  logic                                CC_LEVEL_SEQUENCER_CLOCK_50,
  input  logic                                CC_LEVEL_SEQUENCER_RESET_InHigh,
  input  logic                                CC_LEVEL_SEQUENCER_start_InLow,
  input  logic                                CC_LEVEL_SEQUENCER_levelDone_InHigh,
  output logic [COUNTER_LEVELS_DATAWIDTH-1:0] CC_LEVEL_SEQUENCER_level_Out,
  output logic                                CC_LEVEL_SEQUENCER_levelLoad_OutHigh,
  output logic                                CC_LEVEL_SEQUENCER_pause_OutHigh,
  output logic                                CC_LEVEL_SEQUENCER_win_OutLow
);

  localparam int CW = $clog2(PAUSE_CYCLES + 1);
  localparam int LW = COUNTER_LEVELS_DATAWIDTH;

  logic clk;
  logic srst;
  logic start_press;
  logic done_edge;

  assign clk  = CC_LEVEL_SEQUENCER_CLOCK_50;
  assign srst = CC_LEVEL_SEQUENCER_RESET_InHigh;

  cc_edge_detect #(.RESET_PREV(1'b1)) u_start_edge (
    .clk      (clk),
    .srst     (srst),
    .sig_in   (~CC_LEVEL_SEQUENCER_start_InLow),
    .edge_out (start_press)
  );

  cc_edge_detect #(.RESET_PREV(1'b1)) u_done_edge (
    .clk      (clk),
    .srst     (srst),
    .sig_in   (CC_LEVEL_SEQUENCER_levelDone_InHigh),
    .edge_out (done_edge)
  );

  level_state_e  state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_q, load_d;
  logic          pause_q, pause_d;
  logic          win_n_q, win_n_d;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    load_d  = 1'b0;
    pause_d = pause_q;
    win_n_d = win_n_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_press) begin
          level_d = LW'(1);
          load_d  = 1'b1;
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (done_edge) begin
          if (level_q < LW'(MAX_LEVEL)) begin
            level_d = level_q + LW'(1);
            cnt_d   = CW'(PAUSE_CYCLES - 1);
            pause_d = 1'b1;
            state_d = ST_PAUSE;
          end else begin
            win_n_d = 1'b0;
            state_d = ST_WIN;
          end
        end
      end
      ST_PAUSE: begin
        // Counter is loaded with PAUSE_CYCLES-1 so the exit cycle is the last pause cycle.
        if (cnt_q == '0) begin
          pause_d = 1'b0;
          load_d  = 1'b1;
          state_d = ST_PLAY;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_WIN: begin
        if (start_press) begin
          win_n_d = 1'b1;
          level_d = LW'(1);
          load_d  = 1'b1;
          state_d = ST_PLAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      pause_q <= 1'b0;
      win_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      pause_q <= pause_d;
      win_n_q <= win_n_d;
    end
  end

  assign CC_LEVEL_SEQUENCER_level_Out         = level_q;
  assign CC_LEVEL_SEQUENCER_levelLoad_OutHigh = load_q;
  assign CC_LEVEL_SEQUENCER_pause_OutHigh     = pause_q;
  assign CC_LEVEL_SEQUENCER_win_OutLow        = win_n_q;

endmodule
